// File: rtl/stepdown_ctrl_pkg.sv
// Shared types and defaults for the stepdown dead-time controller.
package stepdown_ctrl_pkg;

  localparam int DTW_DEF  = 6;
  localparam int MINW_DEF = 6;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_H  = 3'd1,
    ST_HS_ON = 3'd2,
    ST_DT_L  = 3'd3,
    ST_LS_ON = 3'd4
  } state_t;

endpackage

// File: rtl/stepdown_sync.sv
// NSYNC-deep single-bit synchronizer, async active-low reset.
module stepdown_sync #(
  parameter int NSYNC = 2
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);

  logic [NSYNC-1:0] sr;

  // shift the asynchronous input through the flop chain
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sr <= '0;
    else         sr <= {sr[NSYNC-2:0], d};
  end

  assign q = sr[NSYNC-1];

endmodule

// File: rtl/stepdown_deadtime_ctrl.sv
// Non-overlap controller: turns the loop PWM command into registered
// high-side/low-side enables with dead time, min HS on-time and DCM cutoff.
module stepdown_deadtime_ctrl
  import stepdown_ctrl_pkg::*;
#(
  parameter int DTW    = DTW_DEF,
  parameter int MINW   = MINW_DEF,
  parameter int MIN_ON = 3,
  parameter int NSYNC  = 2
) (
  input  logic           CELCLK,
  input  logic           CELRSTB,
  input  logic           CELV,
  input  logic           CELG,
  input  logic           SUB,
  input  logic           en,
  input  logic           pwm_in,
  input  logic           zcd,
  input  logic           fault,
  input  logic [DTW-1:0] dt_hs,
  input  logic [DTW-1:0] dt_ls,
  output logic           hs_on,
  output logic           ls_on,
  output logic           dt_act,
  output logic           flt_lat
);

  // MIN_ON of 0 behaves as a single cycle
  localparam int               MIN_EFF_I = (MIN_ON < 1) ? 1 : MIN_ON;
  localparam logic [MINW-1:0]  MIN_EFF   = MIN_EFF_I[MINW-1:0];

  // supply/substrate pins carry no logic
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  logic pwm_s, zcd_s, flt_s;

  stepdown_sync #(.NSYNC(NSYNC)) u_sync_pwm (.gclk(CELCLK), .grst_n(CELRSTB), .d(pwm_in), .q(pwm_s));
  stepdown_sync #(.NSYNC(NSYNC)) u_sync_zcd (.gclk(CELCLK), .grst_n(CELRSTB), .d(zcd),    .q(zcd_s));
  stepdown_sync #(.NSYNC(NSYNC)) u_sync_flt (.gclk(CELCLK), .grst_n(CELRSTB), .d(fault),  .q(flt_s));

  state_t          state, nxt;
  logic [DTW-1:0]  dt_cnt, dt_lim;
  logic [MINW-1:0] on_cnt, on_inc;
  logic [DTW-1:0]  dt_hs_eff, dt_ls_eff;
  logic            dt_done, min_done, dt_entry;

  // zero dead time is stretched to one cycle so both-low is always visible
  assign dt_hs_eff = (dt_hs == '0) ? DTW'(1) : dt_hs;
  assign dt_ls_eff = (dt_ls == '0) ? DTW'(1) : dt_ls;

  // dt_cnt counts completed DT cycles; the current cycle is the last one
  assign dt_done  = (dt_cnt >= (dt_lim - DTW'(1)));
  // on_inc includes the current HS_ON cycle
  assign on_inc   = (on_cnt == '1) ? on_cnt : on_cnt + MINW'(1);
  assign min_done = (on_inc >= MIN_EFF);
  assign dt_entry = (nxt != state) && ((nxt == ST_DT_H) || (nxt == ST_DT_L));

  // next-state: fault and disable override every state
  always_comb begin
    nxt = state;
    if (flt_s || !en) nxt = ST_OFF;
    else begin
      case (state)
        ST_OFF:   if (!flt_lat && pwm_s) nxt = ST_DT_H;
        ST_DT_H:  if (dt_done) nxt = ST_HS_ON;
        ST_HS_ON: if (!pwm_s && min_done) nxt = ST_DT_L;
        ST_DT_L:  if (dt_done) nxt = zcd_s ? ST_OFF : ST_LS_ON;
        ST_LS_ON: if (zcd_s) nxt = ST_OFF;
                  else if (pwm_s) nxt = ST_DT_H;
        default:  nxt = ST_OFF;
      endcase
    end
  end

  // state plus outputs decoded from next state, so enables change on the transition edge
  always_ff @(posedge CELCLK or negedge CELRSTB) begin
    if (!CELRSTB) begin
      state  <= ST_OFF;
      hs_on  <= 1'b0;
      ls_on  <= 1'b0;
      dt_act <= 1'b0;
    end else begin
      state  <= nxt;
      hs_on  <= (nxt == ST_HS_ON);
      ls_on  <= (nxt == ST_LS_ON);
      dt_act <= (nxt == ST_DT_H) || (nxt == ST_DT_L);
    end
  end

  // dead-time counter; the programmed length is captured once per DT entry
  always_ff @(posedge CELCLK or negedge CELRSTB) begin
    if (!CELRSTB) begin
      dt_cnt <= '0;
      dt_lim <= '0;
    end else if (dt_entry) begin
      dt_cnt <= '0;
      dt_lim <= (nxt == ST_DT_H) ? dt_hs_eff : dt_ls_eff;
    end else if (nxt == ST_OFF) begin
      dt_cnt <= '0;
    end else if (((state == ST_DT_H) || (state == ST_DT_L)) && (dt_cnt != '1)) begin
      dt_cnt <= dt_cnt + DTW'(1);
    end
  end

  // HS on-time counter, saturating
  always_ff @(posedge CELCLK or negedge CELRSTB) begin
    if (!CELRSTB)                                    on_cnt <= '0;
    else if ((nxt == ST_HS_ON) && (state != ST_HS_ON)) on_cnt <= '0;
    else if (nxt == ST_OFF)                          on_cnt <= '0;
    else if (state == ST_HS_ON)                      on_cnt <= on_inc;
  end

  // fault latch: set by any synced fault, released only by a disabled, fault-free cycle
  always_ff @(posedge CELCLK or negedge CELRSTB) begin
    if (!CELRSTB)   flt_lat <= 1'b0;
    else if (flt_s) flt_lat <= 1'b1;
    else if (!en)   flt_lat <= 1'b0;
  end

endmodule

// File: tb/tb_stepdown_deadtime_ctrl.sv
// Bench for stepdown_deadtime_ctrl: per-scenario expected traces queued
// when stimulus is applied, compared cycle by cycle after each edge.
module tb_stepdown_deadtime_ctrl;

  logic       CELCLK  = 1'b0;
  logic       CELRSTB = 1'b1;
  logic       CELV = 1'b1, CELG = 1'b0, SUB = 1'b0;
  logic       en = 1'b0, pwm_in = 1'b0, zcd = 1'b0, fault = 1'b0;
  logic [5:0] dt_hs = 6'd1, dt_ls = 6'd1;
  logic       hs_on, ls_on, dt_act, flt_lat;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  wire  [3:0] obs = {hs_on, ls_on, dt_act, flt_lat};

  stepdown_deadtime_ctrl #(.DTW(6), .MINW(6), .MIN_ON(3), .NSYNC(2)) dut (
    .CELCLK(CELCLK), .CELRSTB(CELRSTB), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .pwm_in(pwm_in), .zcd(zcd), .fault(fault),
    .dt_hs(dt_hs), .dt_ls(dt_ls),
    .hs_on(hs_on), .ls_on(ls_on), .dt_act(dt_act), .flt_lat(flt_lat)
  );

  always #5 CELCLK = ~CELCLK;

  // step n cycles, leaving time at 1 unit after the last edge
  task automatic tick(input int n);
    repeat (n) begin @(posedge CELCLK); #1; end
  endtask

  // return to a settled OFF state with en=1 and all async inputs low
  task automatic go_idle();
    en = 1'b0; pwm_in = 1'b0; zcd = 1'b0; fault = 1'b0;
    tick(4);
    en = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    logic [3:0] e;
    en = 1'b1; pwm_in = 1'b0;
    #1 CELRSTB = 1'b0;
    #1;
    total++;
    if (obs !== 4'b0000) begin bad++; $display("FAIL reset_async got=%b exp=0000", obs); end
    tick(3);
    CELRSTB = 1'b1;
    for (int j = 0; j < 20; j++) exp_q.push_back(4'b0000);
    for (int j = 0; j < 20; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_idle j=%0d got=%b exp=%b", j, obs, e); end
    end
  endtask

  // dt_hs=4: dt_act for edges k+2..k+5, hs_on from k+6
  task automatic test_latency();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd4;
    pwm_in = 1'b1;
    for (int j = 0; j < 10; j++) exp_q.push_back({j >= 6, 1'b0, j >= 2 && j <= 5, 1'b0});
    for (int j = 0; j < 10; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL latency j=%0d got=%b exp=%b", j, obs, e); end
    end
  endtask

  // dt_hs=0 acts as one cycle of dead time
  task automatic test_dt_zero();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd0;
    pwm_in = 1'b1;
    for (int j = 0; j < 6; j++) exp_q.push_back({j >= 3, 1'b0, j == 2, 1'b0});
    for (int j = 0; j < 6; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL dt_zero j=%0d got=%b exp=%b", j, obs, e); end
    end
  endtask

  // changing dt_hs inside DT_H must not shorten the running dead time
  task automatic test_dt_resample();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd5;
    pwm_in = 1'b1;
    for (int j = 0; j < 10; j++) exp_q.push_back({j >= 7, 1'b0, j >= 2 && j <= 6, 1'b0});
    for (int j = 0; j < 10; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL dt_resample j=%0d got=%b exp=%b", j, obs, e); end
      if (j == 2) dt_hs = 6'd1;
    end
  endtask

  // 1-cycle pwm pulse: hs_on exactly 3 cycles, 2 dead cycles, then ls_on
  task automatic test_min_on();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd1; dt_ls = 6'd2;
    pwm_in = 1'b1;
    for (int j = 0; j < 12; j++)
      exp_q.push_back({j >= 3 && j <= 5, j >= 8, j == 2 || j == 6 || j == 7, 1'b0});
    for (int j = 0; j < 12; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL min_on j=%0d got=%b exp=%b", j, obs, e); end
      if (j == 0) pwm_in = 1'b0;
    end
  endtask

  // from LS_ON: zcd cuts ls_on, next pwm rise goes OFF->DT_H->HS_ON
  task automatic test_zcd();
    logic [3:0] e;
    zcd = 1'b1;
    for (int j = 0; j < 10; j++) exp_q.push_back({j >= 7, j <= 1, j == 6, 1'b0});
    for (int j = 0; j < 10; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL zcd j=%0d got=%b exp=%b", j, obs, e); end
      if (j == 2) zcd = 1'b0;
      if (j == 3) pwm_in = 1'b1;
    end
  endtask

  // fault pulse in HS_ON latches off; pwm ignored until a single en=0 cycle
  task automatic test_fault();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd1;
    pwm_in = 1'b1;
    for (int j = 0; j < 21; j++) begin
      if (j < 7)        exp_q.push_back({j >= 3, 1'b0, j == 2, 1'b0});
      else if (j <= 17) exp_q.push_back(4'b0001);
      else if (j == 18) exp_q.push_back(4'b0000);
      else if (j == 19) exp_q.push_back(4'b0010);
      else              exp_q.push_back(4'b1000);
    end
    for (int j = 0; j < 21; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL fault j=%0d got=%b exp=%b", j, obs, e); end
      if (j == 4) fault = 1'b1;
      if (j == 5) fault = 1'b0;
      if (j >= 8 && j < 14) pwm_in = j[0];
      if (j == 14) pwm_in = 1'b1;
      if (j == 17) en = 1'b0;
      if (j == 18) en = 1'b1;
    end
  endtask

  // en=0 in HS_ON drops straight to OFF with no dead-time sequence
  task automatic test_disable();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd1; dt_ls = 6'd1;
    pwm_in = 1'b1;
    for (int j = 0; j < 10; j++) exp_q.push_back({j >= 3 && j <= 4, 1'b0, j == 2, 1'b0});
    for (int j = 0; j < 10; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL disable j=%0d got=%b exp=%b", j, obs, e); end
      if (j == 4) begin en = 1'b0; pwm_in = 1'b0; end
      if (j == 6) en = 1'b1;
    end
  endtask

  // HS -> DT_L -> LS -> DT_H -> HS without passing through OFF
  task automatic test_back_to_back();
    logic [3:0] e;
    go_idle();
    dt_hs = 6'd2; dt_ls = 6'd1;
    pwm_in = 1'b1;
    for (int j = 0; j < 16; j++)
      exp_q.push_back({(j >= 4 && j <= 6) || j >= 14, j >= 8 && j <= 11,
                       j == 2 || j == 3 || j == 7 || j == 12 || j == 13, 1'b0});
    for (int j = 0; j < 16; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL back_to_back j=%0d got=%b exp=%b", j, obs, e); end
      if (j == 2) pwm_in = 1'b0;
      if (j == 9) pwm_in = 1'b1;
    end
  endtask

  // async reset while HS is on, then restart from OFF with pwm still high
  task automatic test_reset_mid();
    logic [3:0] e;
    CELRSTB = 1'b0;
    #2;
    total++;
    if (obs !== 4'b0000) begin bad++; $display("FAIL reset_mid got=%b exp=0000", obs); end
    tick(1);
    CELRSTB = 1'b1;
    for (int j = 0; j < 6; j++) exp_q.push_back({j >= 4, 1'b0, j == 2 || j == 3, 1'b0});
    for (int j = 0; j < 6; j++) begin
      @(posedge CELCLK); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_resume j=%0d got=%b exp=%b", j, obs, e); end
    end
  endtask

  // random traffic: no overlap and a both-low cycle on every HS<->LS change
  task automatic test_random();
    logic ph, pl;
    go_idle();
    ph = hs_on; pl = ls_on;
    for (int j = 0; j < 10000; j++) begin
      if ($urandom_range(7) == 0) pwm_in = ~pwm_in;
      zcd   = ($urandom_range(15) == 0);
      dt_hs = 6'($urandom_range(7));
      dt_ls = 6'($urandom_range(7));
      en    = ($urandom_range(199) != 0);
      fault = ($urandom_range(499) == 0);
      @(posedge CELCLK); #1;
      total++;
      if ((hs_on && ls_on) || (ph && ls_on) || (pl && hs_on)) begin
        bad++;
        $display("FAIL random_overlap j=%0d got hs=%b ls=%b prev hs=%b ls=%b exp no overlap", j, hs_on, ls_on, ph, pl);
      end
      ph = hs_on; pl = ls_on;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_dt_zero();
    test_dt_resample();
    test_min_on();
    test_zcd();
    test_fault();
    test_disable();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
